// File: rtl/input_ctrl_pkg.sv
// input_ctrl_pkg: shared definitions for the input controller.
//   - coin_state_e     : coin shaper FSM states
//   - Sc* localparams  : PS/2 set-2 scan codes mapped to player controls
//   - Joy* localparams : bit positions within the 11-bit joystick / key vectors
//   - coin_load        : counter load value for a pulse/gap length
//   - socd_filter      : opposing-direction cancellation on {up,down,left,right}
package input_ctrl_pkg;

    typedef enum logic [1:0] {
        CoinIdle,
        CoinPulse,
        CoinGap
    } coin_state_e;

    // Player 1 scan codes
    localparam logic [7:0] ScP1Up      = 8'h75;
    localparam logic [7:0] ScP1Down    = 8'h72;
    localparam logic [7:0] ScP1Left    = 8'h6B;
    localparam logic [7:0] ScP1Right   = 8'h74;
    localparam logic [7:0] ScP1B1      = 8'h14;
    localparam logic [7:0] ScP1B2      = 8'h11;
    localparam logic [7:0] ScP1B3      = 8'h29;
    localparam logic [7:0] ScP1Start   = 8'h16;
    localparam logic [7:0] ScP1Coin    = 8'h2E;
    localparam logic [7:0] ScP1Pause   = 8'h4D;
    localparam logic [7:0] ScP1Service = 8'h46;

    // Player 2 scan codes (no keyboard pause for player 2)
    localparam logic [7:0] ScP2Up      = 8'h2D;
    localparam logic [7:0] ScP2Down    = 8'h2B;
    localparam logic [7:0] ScP2Left    = 8'h23;
    localparam logic [7:0] ScP2Right   = 8'h34;
    localparam logic [7:0] ScP2B1      = 8'h1C;
    localparam logic [7:0] ScP2B2      = 8'h1B;
    localparam logic [7:0] ScP2B3      = 8'h15;
    localparam logic [7:0] ScP2Start   = 8'h1E;
    localparam logic [7:0] ScP2Coin    = 8'h36;
    localparam logic [7:0] ScP2Service = 8'h45;

    // Joystick bit layout, reused for the key registers
    localparam int unsigned JoyRight   = 0;
    localparam int unsigned JoyLeft    = 1;
    localparam int unsigned JoyDown    = 2;
    localparam int unsigned JoyUp      = 3;
    localparam int unsigned JoyB1      = 4;
    localparam int unsigned JoyB2      = 5;
    localparam int unsigned JoyB3      = 6;
    localparam int unsigned JoyStart   = 7;
    localparam int unsigned JoyCoin    = 8;
    localparam int unsigned JoyPause   = 9;
    localparam int unsigned JoyService = 10;

    // Counter counts down to 0 inclusive, so load len-1; a zero length saturates at 0.
    function automatic logic [23:0] coin_load(input logic [23:0] len);
        return (len == 24'd0) ? 24'd0 : len - 24'd1;
    endfunction

    // dir = {up,down,left,right}; both of an opposing pair high -> both low.
    function automatic logic [3:0] socd_filter(input logic [3:0] dir, input logic en);
        logic [3:0] res;
        res = dir;
        if (en && dir[3] && dir[2]) res[3:2] = 2'b00;
        if (en && dir[1] && dir[0]) res[1:0] = 2'b00;
        return res;
    endfunction

endpackage

// File: rtl/coin_pulse.sv
// coin_pulse: shapes a coin trigger into a fixed-length pulse followed by a
// mandatory low gap. Triggers arriving during the pulse or gap are dropped.
//   clk_sys   : system clock
//   rst_sys_n : asynchronous active-low reset
//   trig_i    : single-cycle rising-edge indication of the merged coin input
//   coin_o    : registered coin pulse, high exactly while in CoinPulse
module coin_pulse #(
    parameter logic [23:0] PULSE_LEN = 24'd960000,
    parameter logic [23:0] GAP_LEN   = 24'd960000
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic trig_i,
    output logic coin_o
);
    import input_ctrl_pkg::*;

    coin_state_e state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        coin_q, coin_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CoinIdle: begin
                if (trig_i) begin
                    state_d = CoinPulse;
                    cnt_d   = coin_load(PULSE_LEN);
                end
            end
            CoinPulse: begin
                if (cnt_q == 24'd0) begin
                    state_d = CoinGap;
                    cnt_d   = coin_load(GAP_LEN);
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            CoinGap: begin
                if (cnt_q == 24'd0) begin
                    state_d = CoinIdle;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = CoinIdle;
                cnt_d   = 24'd0;
            end
        endcase
        // Registered copy of "next state is PULSE" keeps coin_o glitch-free.
        coin_d = (state_d == CoinPulse);
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= CoinIdle;
            cnt_q   <= 24'd0;
            coin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
        end
    end

    assign coin_o = coin_q;

endmodule

// File: rtl/input_ctrl.sv
// input_ctrl: merges PS/2 keyboard events with two joysticks into per-player
// controls with optional SOCD cleaning, coin pulse shaping and pause latches.
//   clk_sys, rst_sys_n       : clock, asynchronous active-low reset
//   ps2_key[10:0]            : {toggle, pressed, extended, scan code}
//   joystick_0/1[10:0]       : {service,pause,coin,start,B3,B2,B1,up,down,left,right}
//   p1_dir/p2_dir[3:0]       : {up,down,left,right}, registered
//   p1_buttons/p2_buttons    : {B3,B2,B1}, registered
//   p1_start/p2_start        : registered levels
//   service1/service2        : registered levels
//   p1_coin/p2_coin          : shaped coin pulses
//   p1_pause/p2_pause        : pause latches toggled by pause rising edges
module input_ctrl #(
    parameter logic [23:0] COIN_PULSE_LEN = 24'd960000,
    parameter logic [23:0] COIN_GAP_LEN   = 24'd960000,
    parameter bit          SOCD_CLEAN     = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic [10:0] ps2_key,
    input  logic [10:0] joystick_0,
    input  logic [10:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p1_buttons,
    output logic [2:0]  p2_buttons,
    output logic        p1_start,
    output logic        p2_start,
    output logic        service1,
    output logic        service2,
    output logic        p1_coin,
    output logic        p2_coin,
    output logic        p1_pause,
    output logic        p2_pause
);
    import input_ctrl_pkg::*;

    logic        primed_q, primed_d;
    logic        toggle_q, toggle_d;
    logic [10:0] p1_key_q, p1_key_d, p2_key_q, p2_key_d;
    logic [10:0] p1_m, p2_m;
    logic        key_evt;

    logic [3:0]  p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
    logic [2:0]  p1_btn_q, p1_btn_d, p2_btn_q, p2_btn_d;
    logic        p1_start_q, p1_start_d, p2_start_q, p2_start_d;
    logic        svc1_q, svc1_d, svc2_q, svc2_d;
    logic        coin1_prev_q, coin1_prev_d, coin2_prev_q, coin2_prev_d;
    logic        pause1_prev_q, pause1_prev_d, pause2_prev_q, pause2_prev_d;
    logic        pause1_q, pause1_d, pause2_q, pause2_d;
    logic        coin1_rise, coin2_rise;

    // Extended-code flag is deliberately not decoded.
    logic unused_ps2_ext;
    assign unused_ps2_ext = ps2_key[8];

    always_comb begin
        // The first cycle after reset only captures the toggle, so a toggle
        // already high at release is not mistaken for an event.
        primed_d = 1'b1;
        toggle_d = ps2_key[10];
        key_evt  = primed_q && (ps2_key[10] != toggle_q);

        p1_key_d = p1_key_q;
        p2_key_d = p2_key_q;
        if (key_evt) begin
            case (ps2_key[7:0])
                ScP1Up:      p1_key_d[JoyUp]      = ps2_key[9];
                ScP1Down:    p1_key_d[JoyDown]    = ps2_key[9];
                ScP1Left:    p1_key_d[JoyLeft]    = ps2_key[9];
                ScP1Right:   p1_key_d[JoyRight]   = ps2_key[9];
                ScP1B1:      p1_key_d[JoyB1]      = ps2_key[9];
                ScP1B2:      p1_key_d[JoyB2]      = ps2_key[9];
                ScP1B3:      p1_key_d[JoyB3]      = ps2_key[9];
                ScP1Start:   p1_key_d[JoyStart]   = ps2_key[9];
                ScP1Coin:    p1_key_d[JoyCoin]    = ps2_key[9];
                ScP1Pause:   p1_key_d[JoyPause]   = ps2_key[9];
                ScP1Service: p1_key_d[JoyService] = ps2_key[9];
                ScP2Up:      p2_key_d[JoyUp]      = ps2_key[9];
                ScP2Down:    p2_key_d[JoyDown]    = ps2_key[9];
                ScP2Left:    p2_key_d[JoyLeft]    = ps2_key[9];
                ScP2Right:   p2_key_d[JoyRight]   = ps2_key[9];
                ScP2B1:      p2_key_d[JoyB1]      = ps2_key[9];
                ScP2B2:      p2_key_d[JoyB2]      = ps2_key[9];
                ScP2B3:      p2_key_d[JoyB3]      = ps2_key[9];
                ScP2Start:   p2_key_d[JoyStart]   = ps2_key[9];
                ScP2Coin:    p2_key_d[JoyCoin]    = ps2_key[9];
                ScP2Service: p2_key_d[JoyService] = ps2_key[9];
                default: ;
            endcase
        end

        // p2_key_q[JoyPause] is never written, so player-2 pause is joystick only.
        p1_m = p1_key_q | joystick_0;
        p2_m = p2_key_q | joystick_1;

        p1_dir_d   = socd_filter({p1_m[JoyUp], p1_m[JoyDown], p1_m[JoyLeft], p1_m[JoyRight]},
                                 SOCD_CLEAN);
        p2_dir_d   = socd_filter({p2_m[JoyUp], p2_m[JoyDown], p2_m[JoyLeft], p2_m[JoyRight]},
                                 SOCD_CLEAN);
        p1_btn_d   = {p1_m[JoyB3], p1_m[JoyB2], p1_m[JoyB1]};
        p2_btn_d   = {p2_m[JoyB3], p2_m[JoyB2], p2_m[JoyB1]};
        p1_start_d = p1_m[JoyStart];
        p2_start_d = p2_m[JoyStart];
        svc1_d     = p1_m[JoyService];
        svc2_d     = p2_m[JoyService];

        // Edge history tracks inputs even while unprimed; edges are only
        // honoured once primed, so inputs held across reset never fire.
        coin1_prev_d  = p1_m[JoyCoin];
        coin2_prev_d  = p2_m[JoyCoin];
        pause1_prev_d = p1_m[JoyPause];
        pause2_prev_d = p2_m[JoyPause];
        coin1_rise    = primed_q && p1_m[JoyCoin] && !coin1_prev_q;
        coin2_rise    = primed_q && p2_m[JoyCoin] && !coin2_prev_q;
        pause1_d      = pause1_q ^ (primed_q && p1_m[JoyPause] && !pause1_prev_q);
        pause2_d      = pause2_q ^ (primed_q && p2_m[JoyPause] && !pause2_prev_q);
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            primed_q      <= 1'b0;
            toggle_q      <= 1'b0;
            p1_key_q      <= 11'd0;
            p2_key_q      <= 11'd0;
            p1_dir_q      <= 4'd0;
            p2_dir_q      <= 4'd0;
            p1_btn_q      <= 3'd0;
            p2_btn_q      <= 3'd0;
            p1_start_q    <= 1'b0;
            p2_start_q    <= 1'b0;
            svc1_q        <= 1'b0;
            svc2_q        <= 1'b0;
            coin1_prev_q  <= 1'b0;
            coin2_prev_q  <= 1'b0;
            pause1_prev_q <= 1'b0;
            pause2_prev_q <= 1'b0;
            pause1_q      <= 1'b0;
            pause2_q      <= 1'b0;
        end else begin
            primed_q      <= primed_d;
            toggle_q      <= toggle_d;
            p1_key_q      <= p1_key_d;
            p2_key_q      <= p2_key_d;
            p1_dir_q      <= p1_dir_d;
            p2_dir_q      <= p2_dir_d;
            p1_btn_q      <= p1_btn_d;
            p2_btn_q      <= p2_btn_d;
            p1_start_q    <= p1_start_d;
            p2_start_q    <= p2_start_d;
            svc1_q        <= svc1_d;
            svc2_q        <= svc2_d;
            coin1_prev_q  <= coin1_prev_d;
            coin2_prev_q  <= coin2_prev_d;
            pause1_prev_q <= pause1_prev_d;
            pause2_prev_q <= pause2_prev_d;
            pause1_q      <= pause1_d;
            pause2_q      <= pause2_d;
        end
    end

    coin_pulse #(
        .PULSE_LEN(COIN_PULSE_LEN),
        .GAP_LEN  (COIN_GAP_LEN)
    ) u_coin1 (
        .clk_sys  (clk_sys),
        .rst_sys_n(rst_sys_n),
        .trig_i   (coin1_rise),
        .coin_o   (p1_coin)
    );

    coin_pulse #(
        .PULSE_LEN(COIN_PULSE_LEN),
        .GAP_LEN  (COIN_GAP_LEN)
    ) u_coin2 (
        .clk_sys  (clk_sys),
        .rst_sys_n(rst_sys_n),
        .trig_i   (coin2_rise),
        .coin_o   (p2_coin)
    );

    assign p1_dir     = p1_dir_q;
    assign p2_dir     = p2_dir_q;
    assign p1_buttons = p1_btn_q;
    assign p2_buttons = p2_btn_q;
    assign p1_start   = p1_start_q;
    assign p2_start   = p2_start_q;
    assign service1   = svc1_q;
    assign service2   = svc2_q;
    assign p1_pause   = pause1_q;
    assign p2_pause   = pause2_q;

endmodule
